// File: rtl/fpu_pkg.sv
// Shared FPU datapath helpers: FSM state type and iteration-count arithmetic
// used by the digit-serial adder and subtractor.
// Contents: state_t {IDLE, RUN}, num_iter(n, k) = ceil(n/k), cnt_width(n, k) = clog2(I)+1.
package fpu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Number of K-bit digits needed to cover an N-bit operand.
   function automatic int num_iter(input int n, input int k);
      return (n + k - 1) / k;
   endfunction

   // Digit counter width; the extra bit keeps a 1-bit counter legal when I == 1.
   function automatic int cnt_width(input int n, input int k);
      return $clog2(num_iter(n, k)) + 1;
   endfunction

endpackage

// File: rtl/digit_serial_subtractor_if.sv
// Start/done handshake bundle shared by the digit-serial arithmetic blocks.
// master: drives start, A, B, Bin and observes S, Bout, busy, done.
// slave : the arithmetic block; samples operands on an accepted start.
interface digit_serial_subtractor_if #(
   parameter int N = 16
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         Bin;
   logic [N-1:0] S;
   logic         Bout;
   logic         busy;
   logic         done;

   modport master (output start, A, B, Bin, input  S, Bout, busy, done);
   modport slave  (input  start, A, B, Bin, output S, Bout, busy, done);
endinterface

// File: rtl/k_bit_subtractor.sv
// Combinational K-bit ripple-borrow subtraction slice: D = A - B - Bin.
// Ports: A, B (K-bit operands), Bin (borrow in), D (K-bit difference), Bout (borrow out).
// Purely combinational; no clock, no state.
module k_bit_subtractor #(
   parameter int K = 6
) (
   input  logic [K-1:0] A,
   input  logic [K-1:0] B,
   input  logic         Bin,
   output logic [K-1:0] D,
   output logic         Bout
);

   always_comb begin
      logic [K:0] bw;
      bw    = '0;
      D     = '0;
      bw[0] = Bin;
      for (int i = 0; i < K; i++) begin
         D[i]    = A[i] ^ B[i] ^ bw[i];
         bw[i+1] = (~A[i] & B[i]) | (~A[i] & bw[i]) | (B[i] & bw[i]);
      end
      Bout = bw[K];
   end

endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial unsigned subtractor S = A - B - Bin, K bits per cycle, LSB digit first.
// Latency: done/S/Bout update I = ceil(N/K) edges after the accepted start; one op per I+1 cycles.
// Ports: CLOCK_50, rst_n (async active-low), bus (slave: start/A/B/Bin in, S/Bout/busy/done out).
// Build option SUB_SATURATE_EN: floor S at zero whenever the final borrow is set.
module digit_serial_subtractor
   import fpu_pkg::*;
#(
   parameter int N = 16,
   parameter int K = 6
) (
   input  logic                    CLOCK_50,
   input  logic                    rst_n,
   digit_serial_subtractor_if.slave bus
);

   localparam int I  = num_iter(N, K);
   localparam int P  = I * K;
   localparam int CW = cnt_width(N, K);

   state_t          state, state_nx;
   logic [P-1:0]    a_reg, a_nx;
   logic [P-1:0]    b_reg, b_nx;
   logic [P-1:0]    s_acc, s_acc_nx;
   logic            borrow, borrow_nx;
   logic [CW-1:0]   count, count_nx;
   logic [N-1:0]    s_q, s_nx;
   logic            bout_q, bout_nx;
   logic            done_q, done_nx;

   logic [K-1:0]    slice_d;
   logic            slice_bo;
   logic [P+K-1:0]  s_cat;
   logic [P-1:0]    s_next;

   k_bit_subtractor #(.K(K)) u_slice (
      .A    (a_reg[K-1:0]),
      .B    (b_reg[K-1:0]),
      .Bin  (borrow),
      .D    (slice_d),
      .Bout (slice_bo)
   );

   // New digit enters at the top of the accumulator; after I shifts the first
   // digit has reached bit 0, so the low N bits hold the result.
   assign s_cat  = {slice_d, s_acc};
   assign s_next = P'(s_cat >> K);

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         s_acc  <= '0;
         borrow <= 1'b0;
         count  <= '0;
         s_q    <= '0;
         bout_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         a_reg  <= a_nx;
         b_reg  <= b_nx;
         s_acc  <= s_acc_nx;
         borrow <= borrow_nx;
         count  <= count_nx;
         s_q    <= s_nx;
         bout_q <= bout_nx;
         done_q <= done_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      a_nx      = a_reg;
      b_nx      = b_reg;
      s_acc_nx  = s_acc;
      borrow_nx = borrow;
      count_nx  = count;
      s_nx      = s_q;
      bout_nx   = bout_q;
      done_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx  = RUN;
               a_nx      = P'(bus.A);
               b_nx      = P'(bus.B);
               borrow_nx = bus.Bin;
               count_nx  = '0;
               s_acc_nx  = '0;
            end
         end
         RUN: begin
            // Zero fill means padded digits compute 0 - 0 - borrow, which
            // propagates the true N-bit borrow unchanged to the end.
            a_nx      = a_reg >> K;
            b_nx      = b_reg >> K;
            s_acc_nx  = s_next;
            borrow_nx = slice_bo;
            count_nx  = count + 1'b1;
            if (count == CW'(I - 1)) begin
               state_nx = IDLE;
               bout_nx  = slice_bo;
               done_nx  = 1'b1;
`ifdef SUB_SATURATE_EN
               s_nx     = slice_bo ? '0 : s_next[N-1:0];
`else
               s_nx     = s_next[N-1:0];
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.S    = s_q;
   assign bus.Bout = bout_q;
   assign bus.done = done_q;
   assign bus.busy = (state == RUN);

endmodule

// File: tb/tb_digit_serial_subtractor.sv
module tb_digit_serial_subtractor;

   localparam int I16 = 3;

   logic CLOCK_50;
   logic rst_n;
   int   checks;
   int   errors;

   digit_serial_subtractor_if #(.N(16)) b16 ();
   digit_serial_subtractor_if #(.N(13)) b13a ();
   digit_serial_subtractor_if #(.N(13)) b13b ();
   digit_serial_subtractor_if #(.N(13)) b13c ();

   digit_serial_subtractor #(.N(16), .K(6))  dut16  (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .bus(b16));
   digit_serial_subtractor #(.N(13), .K(4))  dut13a (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .bus(b13a));
   digit_serial_subtractor #(.N(13), .K(1))  dut13b (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .bus(b13b));
   digit_serial_subtractor #(.N(13), .K(13)) dut13c (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .bus(b13c));

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // One complete N=16 operation with exact-latency and done-pulse checks.
   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] es, input logic eb, input string nm);
      @(negedge CLOCK_50);
      b16.start = 1'b1; b16.A = a; b16.B = b; b16.Bin = bin;
      @(negedge CLOCK_50);
      b16.start = 1'b0; b16.A = ~a; b16.B = ~b; b16.Bin = ~bin;
      for (int j = 1; j <= I16; j++) begin
         checks++;
         if (b16.busy !== 1'b1 || b16.done !== 1'b0) begin
            errors++;
            $display("FAIL %s run cycle %0d: busy=%b done=%b, want busy=1 done=0", nm, j, b16.busy, b16.done);
         end
         @(negedge CLOCK_50);
      end
      checks++;
      if (b16.done !== 1'b1 || b16.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s done edge: done=%b busy=%b, want done=1 busy=0", nm, b16.done, b16.busy);
      end
      checks++;
      if (b16.S !== es || b16.Bout !== eb) begin
         errors++;
         $display("FAIL %s result: S=%h Bout=%b, want S=%h Bout=%b", nm, b16.S, b16.Bout, es, eb);
      end
      @(negedge CLOCK_50);
      checks++;
      if (b16.done !== 1'b0 || b16.S !== es || b16.Bout !== eb) begin
         errors++;
         $display("FAIL %s hold: done=%b S=%h Bout=%b, want done=0 S=%h Bout=%b", nm, b16.done, b16.S, b16.Bout, es, eb);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      checks++;
      if (b16.S !== 16'h0000 || b16.Bout !== 1'b0 || b16.busy !== 1'b0 || b16.done !== 1'b0) begin
         errors++;
         $display("FAIL reset: S=%h Bout=%b busy=%b done=%b, want all 0", b16.S, b16.Bout, b16.busy, b16.done);
      end
      checks++;
      if (b13a.S !== 13'h0 || b13b.busy !== 1'b0 || b13c.done !== 1'b0) begin
         errors++;
         $display("FAIL reset13: S=%h busy=%b done=%b, want 0", b13a.S, b13b.busy, b13c.done);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, "basic");
   endtask

   task automatic test_wrap();
`ifdef SUB_SATURATE_EN
      run16(16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1, "underflow");
`else
      run16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, "underflow");
`endif
   endtask

   task automatic test_borrow_in();
      run16(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, "bin_exact");
`ifdef SUB_SATURATE_EN
      run16(16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, "bin_equal");
`else
      run16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "bin_equal");
`endif
   endtask

   task automatic test_back_to_back();
      @(negedge CLOCK_50);
      b16.start = 1'b1; b16.A = 16'h0010; b16.B = 16'h0003; b16.Bin = 1'b0;
      @(negedge CLOCK_50);
      // operands change mid-run; they must only be picked up by the next accept
      b16.A = 16'h0100; b16.B = 16'h0001; b16.Bin = 1'b1;
      repeat (I16) @(negedge CLOCK_50);
      checks++;
      if (b16.done !== 1'b1 || b16.S !== 16'h000D || b16.Bout !== 1'b0) begin
         errors++;
         $display("FAIL b2b first: done=%b S=%h Bout=%b, want done=1 S=000d Bout=0", b16.done, b16.S, b16.Bout);
      end
      @(negedge CLOCK_50);
      checks++;
      if (b16.busy !== 1'b1 || b16.done !== 1'b0) begin
         errors++;
         $display("FAIL b2b reaccept: busy=%b done=%b, want busy=1 done=0", b16.busy, b16.done);
      end
      b16.start = 1'b0; b16.A = 16'hAAAA; b16.B = 16'h5555; b16.Bin = 1'b0;
      repeat (I16) @(negedge CLOCK_50);
      checks++;
      if (b16.done !== 1'b1 || b16.S !== 16'h00FE || b16.Bout !== 1'b0) begin
         errors++;
         $display("FAIL b2b second: done=%b S=%h Bout=%b, want done=1 S=00fe Bout=0", b16.done, b16.S, b16.Bout);
      end
      @(negedge CLOCK_50);
   endtask

   task automatic test_ignore_start();
      int nd;
      int dcyc;
      nd = 0; dcyc = -1;
      @(negedge CLOCK_50);
      b16.start = 1'b1; b16.A = 16'h1234; b16.B = 16'h0234; b16.Bin = 1'b0;
      @(negedge CLOCK_50);
      b16.start = 1'b0;
      @(negedge CLOCK_50);
      b16.start = 1'b1; b16.A = 16'h0005; b16.B = 16'h0001;
      @(negedge CLOCK_50);
      b16.start = 1'b0;
      for (int c = 3; c <= 12; c++) begin
         @(negedge CLOCK_50);
         if (b16.done === 1'b1) begin
            nd++;
            dcyc = c;
         end
      end
      checks++;
      if (nd != 1 || dcyc != I16) begin
         errors++;
         $display("FAIL ignore_start pulses: count=%0d at cycle %0d, want 1 at %0d", nd, dcyc, I16);
      end
      checks++;
      if (b16.S !== 16'h1000 || b16.Bout !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start result: S=%h Bout=%b, want S=1000 Bout=0", b16.S, b16.Bout);
      end
   endtask

   task automatic test_reset_mid();
      int nd;
      nd = 0;
      @(negedge CLOCK_50);
      b16.start = 1'b1; b16.A = 16'h4321; b16.B = 16'h0021; b16.Bin = 1'b0;
      @(negedge CLOCK_50);
      b16.start = 1'b0;
      @(negedge CLOCK_50);
      rst_n = 1'b0;
      #1;
      checks++;
      if (b16.S !== 16'h0000 || b16.Bout !== 1'b0 || b16.busy !== 1'b0 || b16.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: S=%h Bout=%b busy=%b done=%b, want all 0", b16.S, b16.Bout, b16.busy, b16.done);
      end
      repeat (2) @(negedge CLOCK_50);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLOCK_50);
         if (b16.done === 1'b1) nd++;
      end
      checks++;
      if (nd != 0 || b16.S !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid aftermath: done pulses=%0d S=%h, want 0 pulses S=0000", nd, b16.S);
      end
      run16(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, "after_reset");
   endtask

   // Drive the three N=13 variants with identical operands and compare each
   // against a wide-subtraction reference and its own expected latency.
   task automatic sweep13(input logic [12:0] a, input logic [12:0] b, input logic bin);
      logic [13:0] r;
      logic [12:0] es;
      logic        eb;
      int          lat [3];
      int          nd  [3];
      logic [13:0] got [3];
      int          want_lat [3];
      want_lat = '{4, 13, 1};
      r  = {1'b0, a} - {1'b0, b} - {13'd0, bin};
      eb = r[13];
      es = r[12:0];
`ifdef SUB_SATURATE_EN
      if (eb) es = '0;
`endif
      for (int d = 0; d < 3; d++) begin
         lat[d] = -1; nd[d] = 0; got[d] = '0;
      end
      @(negedge CLOCK_50);
      b13a.start = 1'b1; b13a.A = a; b13a.B = b; b13a.Bin = bin;
      b13b.start = 1'b1; b13b.A = a; b13b.B = b; b13b.Bin = bin;
      b13c.start = 1'b1; b13c.A = a; b13c.B = b; b13c.Bin = bin;
      @(negedge CLOCK_50);
      b13a.start = 1'b0; b13b.start = 1'b0; b13c.start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge CLOCK_50);
         if (b13a.done === 1'b1) begin nd[0]++; lat[0] = c; got[0] = {b13a.Bout, b13a.S}; end
         if (b13b.done === 1'b1) begin nd[1]++; lat[1] = c; got[1] = {b13b.Bout, b13b.S}; end
         if (b13c.done === 1'b1) begin nd[2]++; lat[2] = c; got[2] = {b13c.Bout, b13c.S}; end
      end
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (nd[d] != 1 || lat[d] != want_lat[d]) begin
            errors++;
            $display("FAIL sweep13 dut%0d latency: %0d pulses at cycle %0d, want 1 at %0d", d, nd[d], lat[d], want_lat[d]);
         end
         checks++;
         if (got[d] !== {eb, es}) begin
            errors++;
            $display("FAIL sweep13 dut%0d a=%h b=%h bin=%b: {Bout,S}=%h, want %h", d, a, b, bin, got[d], {eb, es});
         end
      end
   endtask

   task automatic test_sweep();
      sweep13(13'h0000, 13'h0000, 1'b0);
      sweep13(13'h0000, 13'h0000, 1'b1);
      sweep13(13'h1FFF, 13'h1FFF, 1'b1);
      sweep13(13'h1000, 13'h0FFF, 1'b0);
      sweep13(13'h0ABC, 13'h1234, 1'b0);
      for (int n = 0; n < 15; n++) begin
         sweep13(13'($urandom), 13'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      b16.start  = 1'b0; b16.A  = '0; b16.B  = '0; b16.Bin  = 1'b0;
      b13a.start = 1'b0; b13a.A = '0; b13a.B = '0; b13a.Bin = 1'b0;
      b13b.start = 1'b0; b13b.A = '0; b13b.B = '0; b13b.Bin = 1'b0;
      b13c.start = 1'b0; b13c.A = '0; b13c.B = '0; b13c.Bin = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_borrow_in();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
